// File: rtl/seg_scan_decoder.sv
// Recovers the four BCD digits shown on a multiplexed 7-segment display by
// sampling its anode/segment lines, publishing complete frames and flagging bad scans.
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic [7:0]  frame_cnt,
    output logic        err_seg,
    output logic        err_anode,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic [10:0]     prev;
    logic [7:0]      stab;
    logic [3:0]      seen;
    logic [3:0][3:0] buffer;
    logic [15:0]     tcnt;

    logic       match;
    logic       accept;
    logic       acc_valid;
    logic       acc_anode;
    logic       acc_bad_seg;
    logic       lone;
    logic [1:0] idx;
    logic [4:0] dec;
    logic [3:0] seen_next;
    logic       tmo_hit;

    // Returns {valid, bcd}; anything outside the ten decimal glyphs is invalid.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   decode = 5'h10;
            7'h30:   decode = 5'h11;
            7'h6D:   decode = 5'h12;
            7'h79:   decode = 5'h13;
            7'h33:   decode = 5'h14;
            7'h5B:   decode = 5'h15;
            7'h5F:   decode = 5'h16;
            7'h70:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h7B:   decode = 5'h19;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        match  = ({an_q, seg_q} == prev);
        accept = match && (stab == 8'(SETTLE - 1));
        lone   = 1'b0;
        idx    = 2'd0;
        case (an_q)
            4'hE:    begin lone = 1'b1; idx = 2'd0; end
            4'hD:    begin lone = 1'b1; idx = 2'd1; end
            4'hB:    begin lone = 1'b1; idx = 2'd2; end
            4'h7:    begin lone = 1'b1; idx = 2'd3; end
            default: begin lone = 1'b0; idx = 2'd0; end
        endcase
        dec         = decode(seg_q);
        acc_valid   = accept && lone && dec[4];
        acc_bad_seg = accept && lone && !dec[4];
        acc_anode   = accept && !lone && (an_q != 4'hF);
        seen_next   = acc_valid ? (seen | (4'b0001 << idx)) : seen;
        tmo_hit     = (tcnt == 16'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            an_q        <= 4'hF;
            seg_q       <= '0;
            prev        <= '0;
            stab        <= '0;
            seen        <= '0;
            buffer      <= '0;
            tcnt        <= '0;
            digits      <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            err_seg     <= 1'b0;
            err_anode   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            prev  <= {an_q, seg_q};
            if (!match)
                stab <= 8'd1;
            else if (stab != 8'(SETTLE))
                stab <= stab + 8'd1;

            frame_valid <= 1'b0;
            err_timeout <= 1'b0;
            err_seg     <= acc_bad_seg;
            err_anode   <= acc_anode;
            if (acc_valid)
                buffer[idx] <= dec[3:0];

            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (acc_valid) begin
                        seen  <= seen_next;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    // Counter parks at its limit so a suppressing accept cannot let it wrap.
                    if (acc_valid || acc_anode)
                        tcnt <= '0;
                    else if (!tmo_hit)
                        tcnt <= tcnt + 16'd1;
                    if (acc_valid) begin
                        seen <= seen_next;
                        if (seen_next == 4'hF)
                            state <= PUBLISH;
                    end else if (tmo_hit && !accept) begin
                        seen        <= '0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                PUBLISH: begin
                    digits      <= buffer;
                    frame_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + 8'd1;
                    seen        <= '0;
                    tcnt        <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: frames, settle boundary, errors, timeout,
// overwrite, reset mid-frame and frame counter wrap.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic        frame_valid;
    logic [7:0]  frame_cnt;
    logic        err_seg;
    logic        err_anode;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_fv = 0, n_es = 0, n_ea = 0, n_et = 0;
    int to_cyc = 0;
    int fv0, es0, ea0, et0, t0;

    seg_scan_decoder #(.SETTLE(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt),
        .err_seg     (err_seg),
        .err_anode   (err_anode),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) n_fv <= n_fv + 1;
        if (err_seg)     n_es <= n_es + 1;
        if (err_anode)   n_ea <= n_ea + 1;
        if (err_timeout) begin
            n_et   <= n_et + 1;
            to_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap;
        @(negedge clk);
        fv0 = n_fv; es0 = n_es; ea0 = n_ea; et0 = n_et;
        @(posedge clk);
        #1;
    endtask

    task automatic frame4321(input int n);
        hold(4'hE, 7'h30, n);
        hold(4'hD, 7'h6D, n);
        hold(4'hB, 7'h79, n);
        hold(4'h7, 7'h33, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        an = 4'hF; seg = '0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", digits, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_errs", {err_seg, err_anode, err_timeout}, 0);
        rst_n = 1'b1;
        hold(4'hF, 7'h00, 4);

        // basic frame
        snap();
        frame4321(6);
        hold(4'hF, 7'h00, 4);
        check("basic_fv", n_fv - fv0, 1);
        check("basic_digits", digits, 16'h4321);
        check("basic_cnt", frame_cnt, 1);
        check("basic_errs", (n_es - es0) + (n_ea - ea0) + (n_et - et0), 0);

        // settle boundary: 3 cycles is too short
        snap();
        hold(4'hE, 7'h7F, 3);
        hold(4'hD, 7'h7E, 6);
        hold(4'hB, 7'h79, 6);
        hold(4'h7, 7'h33, 6);
        hold(4'hF, 7'h00, 4);
        check("settle3_nofv", n_fv - fv0, 0);
        hold(4'hE, 7'h30, 6);
        hold(4'hF, 7'h00, 4);
        check("settle3_fv", n_fv - fv0, 1);
        check("settle3_digits", digits, 16'h4301);
        check("settle3_cnt", frame_cnt, 2);

        // settle boundary: exactly 4 cycles is accepted
        snap();
        hold(4'hE, 7'h7F, 4);
        hold(4'hD, 7'h7E, 6);
        hold(4'hB, 7'h79, 6);
        hold(4'h7, 7'h33, 6);
        hold(4'hF, 7'h00, 4);
        check("settle4_fv", n_fv - fv0, 1);
        check("settle4_digits", digits, 16'h4308);
        check("settle4_cnt", frame_cnt, 3);

        // bad segment pattern leaves digit 0 unseen; partial frame times out
        snap();
        hold(4'hE, 7'h00, 6);
        hold(4'hD, 7'h6D, 6);
        hold(4'hB, 7'h79, 6);
        hold(4'h7, 7'h33, 6);
        hold(4'hF, 7'h00, 24);
        check("badseg_es", n_es - es0, 1);
        check("badseg_nofv", n_fv - fv0, 0);
        check("badseg_et", n_et - et0, 1);
        hold(4'hC, 7'h7E, 6);
        hold(4'hF, 7'h7E, 6);
        hold(4'hF, 7'h5B, 6);
        check("badan_ea", n_ea - ea0, 1);
        check("blank_es", n_es - es0, 1);
        check("blank_et", n_et - et0, 1);
        check("bad_digits_kept", digits, 16'h4308);

        // timeout 16 cycles after the last accept
        snap();
        hold(4'hE, 7'h7E, 6);
        t0 = cyc;
        hold(4'hD, 7'h30, 6);
        hold(4'hF, 7'h00, 30);
        check("tmo_et", n_et - et0, 1);
        check("tmo_time", to_cyc - t0, 21);
        check("tmo_nofv", n_fv - fv0, 0);
        hold(4'hE, 7'h5F, 6);
        hold(4'hD, 7'h70, 6);
        hold(4'hB, 7'h7F, 6);
        hold(4'h7, 7'h7B, 6);
        hold(4'hF, 7'h00, 4);
        check("tmo_fv", n_fv - fv0, 1);
        check("tmo_digits", digits, 16'h9876);
        check("tmo_cnt", frame_cnt, 4);

        // overwrite: latest value for a digit wins
        snap();
        hold(4'hE, 7'h5B, 6);
        hold(4'hE, 7'h7B, 6);
        hold(4'hD, 7'h30, 6);
        hold(4'hB, 7'h6D, 6);
        hold(4'h7, 7'h79, 6);
        hold(4'hF, 7'h00, 4);
        check("ovw_fv", n_fv - fv0, 1);
        check("ovw_digits", digits, 16'h3219);
        check("ovw_cnt", frame_cnt, 5);

        // reset mid-frame
        hold(4'hE, 7'h30, 6);
        hold(4'hD, 7'h6D, 6);
        hold(4'hB, 7'h79, 6);
        an = 4'hF; seg = '0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_digits", digits, 0);
        check("mrst_cnt", frame_cnt, 0);
        check("mrst_outs", {frame_valid, err_seg, err_anode, err_timeout}, 0);
        rst_n = 1'b1;
        snap();
        frame4321(6);
        hold(4'hF, 7'h00, 4);
        check("mrst_fv", n_fv - fv0, 1);
        check("mrst_digits2", digits, 16'h4321);
        check("mrst_cnt2", frame_cnt, 1);

        // frame counter wrap: 255 more frames takes 1 -> 0
        snap();
        for (int i = 0; i < 255; i++) frame4321(5);
        hold(4'hF, 7'h00, 4);
        check("wrap_fv", n_fv - fv0, 255);
        check("wrap_cnt", frame_cnt, 0);
        check("wrap_errs", (n_es - es0) + (n_ea - ea0) + (n_et - et0), 0);
        frame4321(5);
        hold(4'hF, 7'h00, 4);
        check("wrap_cnt_next", frame_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples the anode-select and cathode-segment lines the driver produces and recovers the four displayed decimal digits.
- Publishes a complete 4-digit frame with a one-cycle strobe and flags malformed scan activity.
- Sits on the verification/loopback path and on any board monitor that must read back what the display is showing.

Parameters:
- SETTLE, 4, consecutive identical registered samples of {an,seg} required before a digit is accepted; legal range 2..255.
- TIMEOUT, 1024, cycles without an accepted digit, while a frame is partially collected, before the partial frame is discarded; legal range 16..65535.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- an  in  4  anode select, active-low; an[0]=units digit … an[3]=thousands digit.
- seg  in  7  segments, active-high; bit6=a, bit5=b … bit0=g.
- digits  out  16  last published frame, BCD; [3:0]=units … [15:12]=thousands.
- frame_valid  out  1  one-cycle pulse; digits updated on the same edge.
- frame_cnt  out  8  count of published frames, wraps 255->0.
- err_seg  out  1  one-cycle pulse: accepted sample had a non-decimal segment pattern.
- err_anode  out  1  one-cycle pulse: accepted sample had two or more anodes low.
- err_timeout  out  1  one-cycle pulse: partial frame discarded.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. On a clk edge with rst_n=0, these all clear to 0: outputs; internal an_q, seg_q, the previous-sample register, stability count, seen[3:0], digit buffer, timeout counter. an_q resets to 4'hF. The FSM goes to IDLE.
- Input stage: an and seg are registered once (an_q, seg_q) before any decision.
- Stability count:
  - If {an_q,seg_q} equals the previous cycle's value, the count increments, saturating at SETTLE.
  - Otherwise the count loads 1.
- Accept: fires for exactly one cycle when the count transitions to SETTLE. A held pair is accepted once, never again until it changes.
- Accept handling, by an_q:
  - 4'hF (blank): ignored, no error.
  - Exactly one zero at index k: decode seg_q.
  - Two or more zeros: err_anode pulses; no state change other than the timeout reload.
- Decode table (seg_q -> value): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - Any other pattern: err_seg pulses and seen[k] is unchanged.
  - Valid pattern: buffer[k] <= value, seen[k] <= 1. A repeat for an already-seen digit overwrites it; latest wins.
- FSM:
  - IDLE (seen=0): first valid digit accept -> COLLECT.
  - COLLECT:
    - Every valid or anode-error accept reloads the timeout counter to 0; otherwise it increments.
    - When the accept handling makes seen equal 4'hF: on the following edge, digits <= buffer, frame_valid=1, frame_cnt += 1 (mod 256), seen <= 0, state -> IDLE.
    - When the timeout counter reaches TIMEOUT-1 with no accept that cycle: seen <= 0, err_timeout=1, state -> IDLE.
  - The timeout counter does not run in IDLE.
- Latency: with a pair first present on the ports before edge N and held, the accept occurs at edge N+SETTLE. If that accept completes the frame, frame_valid is high after edge N+SETTLE+1.
- Simultaneous events:
  - An accept in the same cycle the timeout would expire suppresses the timeout.
  - Frame completion and any error never coincide; only one accept per cycle.
- digits holds its value between frames; it never shows partial frames.
- rst_n low mid-frame discards the partial frame and clears frame_cnt.
- All error pulses and frame_valid are single-cycle and mutually independent.

Test Plan:
- Basic frame: SETTLE=4. Drive (an=E,seg=30),(D,6D),(B,79),(7,33), each 6 cycles -> one frame_valid, digits=16'h4321, frame_cnt=1, no errors.
- Settle boundary: drive an=E, seg=7F for 3 cycles, then an=D, seg=7E for 6 cycles -> only digit 1 accepted; after the remaining digits arrive, digits[3:0] is not 8. Repeat with 4 cycles for the first pair -> digit 0 accepted as 8.
- Bad patterns:
  - an=E, seg=00 held 6 cycles -> exactly one err_seg pulse, seen[0] stays 0.
  - an=C, seg=7E -> one err_anode pulse.
  - an=F with any seg -> no pulse.
- Timeout: TIMEOUT=16. Deliver digits 0 and 1, then hold blank -> err_timeout pulses 16 cycles after the last accept; a later full frame publishes correctly with no stale digits.
- Overwrite and wrap: deliver digit 0 as 5 and then as 9 before completing -> digits[3:0]=9. Send 256 frames -> frame_cnt wraps to 0.
- Reset mid-frame: assert rst_n=0 for 1 cycle after 3 digits -> all outputs 0; the next 4 digits publish a frame with frame_cnt=1.
